// File: rtl/lu_dispatch.sv
// lu_dispatch: in-order issue queue feeding the one-cycle logic unit, plus a
// two-entry result FIFO returning tagged results (illegal opcodes flagged, never issued).
module lu_dispatch #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [N-1:0]     lu_a,
    output logic [N-1:0]     lu_b,
    output logic [4:0]       lu_s,
    input  logic [N-1:0]     lu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    function automatic logic op_legal(input logic [4:0] op);
        logic ok;
        case (op)
            5'b01010, 5'b01011, 5'b01100, 5'b01101,
            5'b01110, 5'b01111, 5'b10000, 5'b10001: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [4:0]       q_op_r  [DEPTH];
    logic [N-1:0]     q_a_r   [DEPTH];
    logic [N-1:0]     q_b_r   [DEPTH];
    logic [TAG_W-1:0] q_tag_r [DEPTH];
    logic [AW-1:0]    q_wp_r;
    logic [AW-1:0]    q_rp_r;
    logic [AW:0]      q_cnt_r;
    logic             ready_en_r;

    logic             inflight_r;
    logic             inf_err_r;
    logic [TAG_W-1:0] inf_tag_r;

    logic [N-1:0]     r_res_r [2];
    logic [TAG_W-1:0] r_tag_r [2];
    logic [1:0]       r_err_r;
    logic             r_wp_r;
    logic             r_rp_r;
    logic [1:0]       rcount_r;

    logic             push_s;
    logic             pop_out_s;
    logic             credit_s;
    logic             issue_s;
    logic             head_legal_s;
    logic [2:0]       occ_s;

    // A result slot is reserved per issue, so the result FIFO can never overflow.
    assign occ_s        = {2'b00, inflight_r} + {1'b0, rcount_r};
    assign credit_s     = occ_s < (3'd2 + {2'b00, pop_out_s});
    assign head_legal_s = op_legal(q_op_r[q_rp_r]);
    assign issue_s      = (q_cnt_r != {(AW + 1){1'b0}}) && credit_s;
    assign in_ready     = ready_en_r && (q_cnt_r != FULL_CNT);
    assign push_s       = in_valid && in_ready;
    assign out_valid    = (rcount_r != 2'b00);
    assign pop_out_s    = out_valid && out_ready;

    // Logic-unit drive: head operands only when a legal op issues this cycle.
    always_comb begin
        lu_a = {N{1'b0}};
        lu_b = {N{1'b0}};
        lu_s = 5'b00000;
        if (issue_s && head_legal_s) begin
            lu_a = q_a_r[q_rp_r];
            lu_b = q_b_r[q_rp_r];
            lu_s = q_op_r[q_rp_r];
        end else begin
            lu_a = {N{1'b0}};
            lu_b = {N{1'b0}};
            lu_s = 5'b00000;
        end
    end

    // Result FIFO head presentation; zeros whenever nothing is valid.
    always_comb begin
        out_result = {N{1'b0}};
        out_tag    = {TAG_W{1'b0}};
        out_err    = 1'b0;
        if (out_valid) begin
            out_result = r_res_r[r_rp_r];
            out_tag    = r_tag_r[r_rp_r];
            out_err    = r_err_r[r_rp_r];
        end else begin
            out_result = {N{1'b0}};
            out_tag    = {TAG_W{1'b0}};
            out_err    = 1'b0;
        end
    end

    // Input queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_op_r[i]  <= 5'b00000;
                q_a_r[i]   <= {N{1'b0}};
                q_b_r[i]   <= {N{1'b0}};
                q_tag_r[i] <= {TAG_W{1'b0}};
            end
            q_wp_r     <= {AW{1'b0}};
            q_rp_r     <= {AW{1'b0}};
            q_cnt_r    <= {(AW + 1){1'b0}};
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (push_s) begin
                q_op_r[q_wp_r]  <= in_op;
                q_a_r[q_wp_r]   <= in_a;
                q_b_r[q_wp_r]   <= in_b;
                q_tag_r[q_wp_r] <= in_tag;
                q_wp_r          <= q_wp_r + AW'(1);
            end
            if (issue_s) begin
                q_rp_r <= q_rp_r + AW'(1);
            end
            case ({push_s, issue_s})
                2'b10:   q_cnt_r <= q_cnt_r + (AW + 1)'(1);
                2'b01:   q_cnt_r <= q_cnt_r - (AW + 1)'(1);
                default: q_cnt_r <= q_cnt_r;
            endcase
        end
    end

    // In-flight marker: tracks the op whose lu_c arrives on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
            inf_err_r  <= 1'b0;
            inf_tag_r  <= {TAG_W{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inf_tag_r <= q_tag_r[q_rp_r];
                inf_err_r <= !head_legal_s;
            end
        end
    end

    // Result FIFO: completion write and consumer pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_res_r[i] <= {N{1'b0}};
                r_tag_r[i] <= {TAG_W{1'b0}};
            end
            r_err_r  <= 2'b00;
            r_wp_r   <= 1'b0;
            r_rp_r   <= 1'b0;
            rcount_r <= 2'b00;
        end else begin
            if (inflight_r) begin
                r_res_r[r_wp_r] <= inf_err_r ? {N{1'b0}} : lu_c;
                r_tag_r[r_wp_r] <= inf_tag_r;
                r_err_r[r_wp_r] <= inf_err_r;
                r_wp_r          <= ~r_wp_r;
            end
            if (pop_out_s) begin
                r_rp_r <= ~r_rp_r;
            end
            case ({inflight_r, pop_out_s})
                2'b10:   rcount_r <= rcount_r + 2'd1;
                2'b01:   rcount_r <= rcount_r - 2'd1;
                default: rcount_r <= rcount_r;
            endcase
        end
    end
endmodule

// File: tb/tb_lu_dispatch.sv
// Self-checking bench for lu_dispatch: behavioural logic-unit model, scoreboard
// of expected results, directed scenarios and a randomized phase.
module tb_lu_dispatch;
    localparam int N = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_op = 5'd0;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [N-1:0]     lu_a, lu_b, lu_c;
    logic [4:0]       lu_s;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    always #5 clk = ~clk;

    lu_dispatch #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .lu_a(lu_a), .lu_b(lu_b), .lu_s(lu_s), .lu_c(lu_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_err(out_err)
    );

    typedef struct {
        logic [N-1:0]     res;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               t;
    } rec_t;

    rec_t sb[$];
    rec_t got[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   issue_cnt = 0;
    logic prev_stall = 1'b0;
    logic [N+TAG_W:0] prev_word = '0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic legal_op(input logic [4:0] op);
        return (op >= 5'd10) && (op <= 5'd17);
    endfunction

    function automatic logic [N-1:0] ref_res(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            5'd10:   return a & b;
            5'd11:   return a | b;
            5'd12:   return a ^ b;
            5'd13:   return ~(a & b);
            5'd14:   return ~(a | b);
            5'd15:   return ~(a ^ b);
            5'd16:   return ~a;
            5'd17:   return {N{1'b0}} - a;
            default: return {N{1'b0}};
        endcase
    endfunction

    // Logic unit: registered, one-cycle latency; garbage for anything not issued.
    always @(posedge clk) begin
        lu_c <= legal_op(lu_s) ? ref_res(lu_s, lu_a, lu_b) : 32'hDEAD_BEEF;
    end

    // Monitor: issue legality, output stability, scoreboard, acceptance tracking.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cyc++;
            if (lu_s != 5'd0) begin
                issue_cnt++;
                chk("lu_s_legal", 64'(legal_op(lu_s)), 64'd1);
            end else begin
                chk("idle_operands", 64'(lu_a | lu_b), 64'd0);
            end
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({out_err, out_tag, out_result}), 64'(prev_word));
            end
            chk("rfifo_bound", 64'(dut.rcount_r <= 2'd2), 64'd1);
            if (out_valid && out_ready) begin
                rec_t r;
                r.res = out_result; r.tag = out_tag; r.err = out_err; r.t = cyc;
                got.push_back(r);
                if (sb.size() == 0) begin
                    chk("spurious_result", 64'(out_tag), 64'h7FFF_FFFF);
                end else begin
                    rec_t e;
                    e = sb.pop_front();
                    chk("sb_result", 64'(out_result), 64'(e.res));
                    chk("sb_tag", 64'(out_tag), 64'(e.tag));
                    chk("sb_err", 64'(out_err), 64'(e.err));
                end
            end
            if (in_valid && in_ready) begin
                rec_t e;
                e.res = ref_res(in_op, in_a, in_b);
                e.tag = in_tag;
                e.err = !legal_op(in_op);
                e.t = cyc;
                sb.push_back(e);
                acc_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_err, out_tag, out_result};
        end
    end

    task automatic send(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [TAG_W-1:0] tag);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int limit);
        int k = 0;
        while (got.size() < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (got.size() < n) chk("drain_timeout", 64'(got.size()), 64'(n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]   b2b_op  [7] = '{5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b10001};
        logic [N-1:0] b2b_exp [7] = '{32'h7, 32'h6, 32'hFFFF_FFFE, 32'hFFFF_FFF8, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'hFFFF_FFFB};
        logic [4:0]   bp_op [8];
        logic [N-1:0] bp_a [8];
        logic [N-1:0] bp_b [8];
        int base, k, a_prev;

        // Reset values while rst_n is low.
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_lu", 64'({lu_s, lu_a, lu_b} != '0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single AND: out_valid exactly two edges after acceptance.
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 5'b01010; in_a = 32'hF0F0_F0F0; in_b = 32'hFF00_FF00; in_tag = 5'd3;
        @(negedge clk);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_lat_k", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_lat_k1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_lat_k2", 64'(out_valid), 64'd1);
        chk("t1_result", 64'(out_result), 64'hF000_F000);
        chk("t1_tag", 64'(out_tag), 64'd3);
        chk("t1_err", 64'(out_err), 64'd0);
        @(posedge clk); #1;

        // Back-to-back ops at full throughput.
        got.delete();
        for (int i = 0; i < 7; i++) send(b2b_op[i], 32'h5, 32'h3, TAG_W'(i));
        wait_pops(7, 50);
        if (got.size() >= 7) begin
            for (int i = 0; i < 7; i++) begin
                chk("b2b_result", 64'(got[i].res), 64'(b2b_exp[i]));
                chk("b2b_tag", 64'(got[i].tag), 64'(i));
            end
            chk("b2b_rate", 64'(got[6].t - got[0].t), 64'd6);
        end

        // Illegal opcode between two ANDs.
        got.delete();
        send(5'b01010, 32'h0FF0_0FF0, 32'h00FF_FFFF, 5'd8);
        send(5'b00011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
        send(5'b01010, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd10);
        wait_pops(3, 50);
        if (got.size() >= 3) begin
            chk("ill_tag0", 64'(got[0].tag), 64'd8);
            chk("ill_res0", 64'(got[0].res), 64'h00F0_0FF0);
            chk("ill_tag1", 64'(got[1].tag), 64'd9);
            chk("ill_err1", 64'(got[1].err), 64'd1);
            chk("ill_res1", 64'(got[1].res), 64'd0);
            chk("ill_tag2", 64'(got[2].tag), 64'd10);
            chk("ill_res2", 64'(got[2].res), 64'h0F0F_0000);
            chk("ill_err2", 64'(got[2].err), 64'd0);
        end

        // Backpressure: 8 offers with out_ready low.
        got.delete();
        for (int i = 0; i < 8; i++) begin
            bp_op[i] = 5'($urandom_range(10, 17));
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue_cnt = 0;
        base = acc_cnt;
        for (int c = 0; c < 12; c++) begin
            k = acc_cnt - base;
            if (k < 8) begin
                in_valid = 1'b1; in_op = bp_op[k]; in_a = bp_a[k]; in_b = bp_b[k]; in_tag = TAG_W'(k);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepts", 64'(acc_cnt - base), 64'd6);
        chk("bp_issues", 64'(issue_cnt), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_no_output", 64'(got.size()), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (acc_cnt - base) < 8; c++) begin
            k = acc_cnt - base;
            in_valid = 1'b1; in_op = bp_op[k]; in_a = bp_a[k]; in_b = bp_b[k]; in_tag = TAG_W'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_pops(8, 60);
        if (got.size() >= 8) begin
            for (int i = 0; i < 8; i++) chk("bp_order", 64'(got[i].tag), 64'(i));
        end
        chk("bp_count", 64'(got.size()), 64'd8);

        // Reset with three ops queued and one in flight.
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(5'b01100, $urandom, $urandom, TAG_W'(20 + i));
        out_ready = 1'b1;
        send(5'b01011, $urandom, $urandom, 5'd25);
        out_ready = 1'b0;
        chk("rs_one_popped", 64'(got.size()), 64'd1);
        chk("rs_pre_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rs_out_valid", 64'(out_valid), 64'd0);
        chk("rs_out_result", 64'(out_result), 64'd0);
        chk("rs_out_tag", 64'(out_tag), 64'd0);
        chk("rs_out_err", 64'(out_err), 64'd0);
        chk("rs_in_ready", 64'(in_ready), 64'd0);
        chk("rs_lu", 64'({lu_s, lu_a, lu_b} != '0), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rs_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(5'b01100, 32'h0000_00FF, 32'h0000_0F0F, 5'd30);
        wait_pops(1, 20);
        if (got.size() >= 1) begin
            chk("rs_new_tag", 64'(got[0].tag), 64'd30);
            chk("rs_new_res", 64'(got[0].res), 64'h0000_0FF0);
        end
        chk("rs_new_count", 64'(got.size()), 64'd1);

        // Randomized traffic with random backpressure and some illegal opcodes.
        a_prev = acc_cnt;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || acc_cnt != a_prev) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(10, 17));
                    in_a = $urandom;
                    in_b = $urandom;
                    in_tag = TAG_W'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            a_prev = acc_cnt;
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge clk);
        #1;
        chk("rand_drain", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
